// File: rtl/dm_access_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: each granted access runs
// IDLE -> ACCESS -> RESP, is checked for ctrl/alignment/range legality, and returns a one-cycle response.
module dm_access_arbiter #(
  parameter int ADDR_W = 10,
  parameter bit RR     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqA_Valid,
  output logic        ReqA_Ready,
  input  logic [31:0] ReqA_Addr,
  input  logic        ReqA_Wr,
  input  logic [2:0]  ReqA_Ctrl,
  input  logic [31:0] ReqA_WData,
  output logic        RspA_Valid,
  output logic [31:0] RspA_Data,
  output logic        RspA_Err,
  input  logic        ReqB_Valid,
  output logic        ReqB_Ready,
  input  logic [31:0] ReqB_Addr,
  input  logic        ReqB_Wr,
  input  logic [2:0]  ReqB_Ctrl,
  input  logic [31:0] ReqB_WData,
  output logic        RspB_Valid,
  output logic [31:0] RspB_Data,
  output logic        RspB_Err,
  output logic [31:0] DMAddress,
  output logic [31:0] DMDataWr,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  input  logic [31:0] DMDataRd
);

  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10} state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  state_t      state, state_nxt;
  logic        last_grant, lat_id, lat_wr, lat_err;
  logic [31:0] lat_addr, lat_wdata, rsp_data;
  logic [2:0]  lat_ctrl;
  logic        grant_a, grant_b;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_wr;
  logic [2:0]  sel_ctrl;

  // Range check is done in 33 bits so an address near 2**32 cannot wrap back into range.
  function automatic logic access_err(input logic [31:0] addr, input logic wr, input logic [2:0] ctrl);
    logic        err;
    logic [32:0] size;
    logic [32:0] last;
    err  = 1'b0;
    size = 33'd4;
    case (ctrl)
      3'b000, 3'b100: size = 33'd1;
      3'b001, 3'b101: size = 33'd2;
      3'b010:         size = 33'd4;
      default: begin
        size = 33'd1;
        err  = 1'b1;
      end
    endcase
    if (wr && ctrl[2]) err = 1'b1;
    if ((size == 33'd2) && addr[0]) err = 1'b1;
    if ((size == 33'd4) && (addr[1:0] != 2'b00)) err = 1'b1;
    last = {1'b0, addr} + size - 33'd1;
    if (last >= (33'd1 << ADDR_W)) err = 1'b1;
    return err;
  endfunction

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if ((state == IDLE) && !rst) begin
      if (ReqA_Valid && ReqB_Valid) begin
        if (RR && (last_grant == ID_A)) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = ReqA_Valid;
        grant_b = ReqB_Valid;
      end
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign ReqA_Ready = grant_a;
  assign ReqB_Ready = grant_b;
  assign sel_addr   = grant_b ? ReqB_Addr  : ReqA_Addr;
  assign sel_wdata  = grant_b ? ReqB_WData : ReqA_WData;
  assign sel_wr     = grant_b ? ReqB_Wr    : ReqA_Wr;
  assign sel_ctrl   = grant_b ? ReqB_Ctrl  : ReqA_Ctrl;

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_B;
      lat_id     <= ID_A;
      lat_wr     <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_ctrl   <= 3'b010;
      rsp_data   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant_a || grant_b) begin
        lat_id     <= grant_b;
        last_grant <= grant_b;
        lat_addr   <= sel_addr;
        lat_wdata  <= sel_wdata;
        lat_wr     <= sel_wr;
        lat_ctrl   <= sel_ctrl;
        lat_err    <= access_err(sel_addr, sel_wr, sel_ctrl);
      end
      if (state == ACCESS) begin
        rsp_data <= (!lat_wr && !lat_err) ? DMDataRd : 32'd0;
      end
    end
  end

  // Memory port idles at its reset values; rst also kills a write already on the port.
  always_comb begin
    DMAddress  = 32'd0;
    DMDataWr   = 32'd0;
    DMWr       = 1'b0;
    DMCtrl     = 3'b010;
    RspA_Valid = 1'b0;
    RspA_Data  = 32'd0;
    RspA_Err   = 1'b0;
    RspB_Valid = 1'b0;
    RspB_Data  = 32'd0;
    RspB_Err   = 1'b0;
    case (state)
      ACCESS: begin
        DMAddress = lat_addr;
        DMDataWr  = lat_wdata;
        DMCtrl    = lat_ctrl;
        DMWr      = lat_wr & ~lat_err & ~rst;
      end
      RESP: begin
        if (rst) begin
          RspA_Valid = 1'b0;
        end else if (lat_id == ID_A) begin
          RspA_Valid = 1'b1;
          RspA_Data  = rsp_data;
          RspA_Err   = lat_err;
        end else begin
          RspB_Valid = 1'b1;
          RspB_Data  = rsp_data;
          RspB_Err   = lat_err;
        end
      end
      default: begin
        DMWr = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: a byte-array data memory serves the DUT port, and a separate
// byte-array reference model predicts error flags and load data from the access rules.
module tb_dm_access_arbiter;
  localparam int MSZ = 1024;

  logic clk = 1'b0;
  logic rst;
  logic a_valid, a_ready, a_wr, rspa_valid, rspa_err;
  logic [31:0] a_addr, a_wdata, rspa_data;
  logic [2:0] a_ctrl;
  logic b_valid, b_ready, b_wr, rspb_valid, rspb_err;
  logic [31:0] b_addr, b_wdata, rspb_data;
  logic [2:0] b_ctrl;
  logic [31:0] dm_address, dm_data_wr, dm_data_rd;
  logic dm_wr;
  logic [2:0] dm_ctrl;
  logic fp_a_ready, fp_b_ready, fp_rspa_valid, fp_rspa_err, fp_rspb_valid, fp_rspb_err, fp_dm_wr;
  logic [31:0] fp_rspa_data, fp_rspb_data, fp_dm_address, fp_dm_data_wr, fp_rd;
  logic [2:0] fp_dm_ctrl;

  logic [7:0] mem [0:MSZ-1];
  logic [7:0] ref_mem [0:MSZ-1];
  logic mem_init;
  logic [9:0] rd_a;
  logic [31:0] rd_word;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  assign fp_rd = 32'd0;

  dm_access_arbiter #(.ADDR_W(10), .RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ReqA_Valid(a_valid), .ReqA_Ready(a_ready), .ReqA_Addr(a_addr), .ReqA_Wr(a_wr),
    .ReqA_Ctrl(a_ctrl), .ReqA_WData(a_wdata), .RspA_Valid(rspa_valid), .RspA_Data(rspa_data), .RspA_Err(rspa_err),
    .ReqB_Valid(b_valid), .ReqB_Ready(b_ready), .ReqB_Addr(b_addr), .ReqB_Wr(b_wr),
    .ReqB_Ctrl(b_ctrl), .ReqB_WData(b_wdata), .RspB_Valid(rspb_valid), .RspB_Data(rspb_data), .RspB_Err(rspb_err),
    .DMAddress(dm_address), .DMDataWr(dm_data_wr), .DMWr(dm_wr), .DMCtrl(dm_ctrl), .DMDataRd(dm_data_rd));

  dm_access_arbiter #(.ADDR_W(10), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .ReqA_Valid(a_valid), .ReqA_Ready(fp_a_ready), .ReqA_Addr(a_addr), .ReqA_Wr(a_wr),
    .ReqA_Ctrl(a_ctrl), .ReqA_WData(a_wdata), .RspA_Valid(fp_rspa_valid), .RspA_Data(fp_rspa_data), .RspA_Err(fp_rspa_err),
    .ReqB_Valid(b_valid), .ReqB_Ready(fp_b_ready), .ReqB_Addr(b_addr), .ReqB_Wr(b_wr),
    .ReqB_Ctrl(b_ctrl), .ReqB_WData(b_wdata), .RspB_Valid(fp_rspb_valid), .RspB_Data(fp_rspb_data), .RspB_Err(fp_rspb_err),
    .DMAddress(fp_dm_address), .DMDataWr(fp_dm_data_wr), .DMWr(fp_dm_wr), .DMCtrl(fp_dm_ctrl), .DMDataRd(fp_rd));

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Data memory seen by the DUT: little-endian bytes, B/H stores write the low bytes.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= init_byte(i);
    end else if (dm_wr) begin
      mem[dm_address[9:0]] <= dm_data_wr[7:0];
      if (dm_ctrl == 3'b001 || dm_ctrl == 3'b010) mem[dm_address[9:0] + 10'd1] <= dm_data_wr[15:8];
      if (dm_ctrl == 3'b010) begin
        mem[dm_address[9:0] + 10'd2] <= dm_data_wr[23:16];
        mem[dm_address[9:0] + 10'd3] <= dm_data_wr[31:24];
      end
    end
  end

  always_comb begin
    rd_a = dm_address[9:0];
    rd_word = {mem[rd_a + 10'd3], mem[rd_a + 10'd2], mem[rd_a + 10'd1], mem[rd_a]};
    case (dm_ctrl)
      3'b000:  dm_data_rd = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  dm_data_rd = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  dm_data_rd = {24'd0, rd_word[7:0]};
      3'b101:  dm_data_rd = {16'd0, rd_word[15:0]};
      default: dm_data_rd = rd_word;
    endcase
  end

  function automatic int size_of(input logic [2:0] c);
    if (c == 3'b000 || c == 3'b100) return 1;
    if (c == 3'b001 || c == 3'b101) return 2;
    if (c == 3'b010) return 4;
    return 0;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input bit wr, input logic [2:0] c);
    int s;
    longint last;
    s = size_of(c);
    if (s == 0) return 1'b1;
    if (wr && (c == 3'b100 || c == 3'b101)) return 1'b1;
    if ((addr % s) != 0) return 1'b1;
    last = longint'({32'd0, addr}) + longint'(s) - 64'sd1;
    return last >= MSZ;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] c);
    int i;
    logic [7:0] b0, b1, b2, b3;
    i = int'(addr[9:0]);
    b0 = ref_mem[i];
    b1 = (i + 1 < MSZ) ? ref_mem[i + 1] : 8'd0;
    b2 = (i + 2 < MSZ) ? ref_mem[i + 2] : 8'd0;
    b3 = (i + 3 < MSZ) ? ref_mem[i + 3] : 8'd0;
    case (c)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'd0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] c, input logic [31:0] d);
    int i;
    i = int'(addr[9:0]);
    for (int k = 0; k < size_of(c); k++) ref_mem[i + k] = d[8*k +: 8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request, waits (bounded) for Ready, then samples ACCESS and RESP cycles.
  task automatic do_access(input bit port, input bit wr, input logic [2:0] c, input logic [31:0] addr,
                           input logic [31:0] wd, output int wt, output bit dmwr, output bit own_v,
                           output bit oth_v, output logic [31:0] data, output bit err);
    wt = 0; dmwr = 1'b0; own_v = 1'b0; oth_v = 1'b0; data = 32'd0; err = 1'b0;
    @(negedge clk);
    if (port) begin b_valid = 1'b1; b_wr = wr; b_ctrl = c; b_addr = addr; b_wdata = wd; end
    else begin a_valid = 1'b1; a_wr = wr; a_ctrl = c; a_addr = addr; a_wdata = wd; end
    #1;
    while (!(port ? b_ready : a_ready) && wt < 20) begin
      @(negedge clk); #1; wt++;
    end
    if (wt >= 20) begin
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    dmwr = dm_wr;
    @(negedge clk);
    own_v = port ? rspb_valid : rspa_valid;
    oth_v = port ? rspa_valid : rspb_valid;
    data  = port ? rspb_data : rspa_data;
    err   = port ? rspb_err : rspa_err;
  endtask

  // One access checked against the reference model; updates the model on a good store.
  task automatic check_access(input string nm, input bit port, input bit wr, input logic [2:0] c,
                              input logic [31:0] addr, input logic [31:0] wd);
    int wt; bit dmwr, own_v, oth_v, err, e;
    logic [31:0] data, exp;
    e = model_err(addr, wr, c);
    exp = (wr || e) ? 32'd0 : model_load(addr, c);
    do_access(port, wr, c, addr, wd, wt, dmwr, own_v, oth_v, data, err);
    n_checks++;
    if (wt !== 0 || own_v !== 1'b1 || oth_v !== 1'b0)
      $display("FAIL %s handshake/rsp: wait=%0d own=%0b other=%0b required 0/1/0", nm, wt, own_v, oth_v);
    else n_pass++;
    n_checks++;
    if (err !== e || data !== exp)
      $display("FAIL %s result: err=%0b data=%h required err=%0b data=%h", nm, err, data, e, exp);
    else n_pass++;
    n_checks++;
    if (dmwr !== (wr && !e)) $display("FAIL %s dmwr: got %0b required %0b", nm, dmwr, wr && !e);
    else n_pass++;
    if (wr && !e) model_store(addr, c, wd);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    a_valid = 1'b1; a_wr = 1'b0; a_ctrl = 3'b010; a_addr = 32'h10; a_wdata = 32'd0;
    b_valid = 1'b1; b_wr = 1'b0; b_ctrl = 3'b010; b_addr = 32'h20; b_wdata = 32'd0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready, rspa_valid, rspb_valid, dm_wr} !== 5'b00000 || dm_address !== 32'd0 ||
        dm_data_wr !== 32'd0 || dm_ctrl !== 3'b010)
      $display("FAIL reset_state: rdy=%b%b rsp=%b%b dmwr=%b addr=%h wd=%h ctrl=%b required 0000 0 0 0 010",
               a_ready, b_ready, rspa_valid, rspb_valid, dm_wr, dm_address, dm_data_wr, dm_ctrl);
    else n_pass++;
    a_valid = 1'b0; b_valid = 1'b0; mem_init = 1'b0; rst = 1'b0;
  endtask

  task automatic test_store_load();
    check_access("store_w_deadbeef", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check_access("load_w_deadbeef", 1'b0, 1'b0, 3'b010, 32'h10, 32'd0);
    n_checks++;
    if (model_load(32'h10, 3'b010) !== 32'hDEADBEEF || mem[16] !== 8'hEF)
      $display("FAIL store_mem_content: mem[0x10]=%h required ef", mem[16]);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    bit rsp_seen; int k; int ca, cb;
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_wr = 1'b0; a_ctrl = 3'b010; a_addr = 32'h10;
    b_valid = 1'b1; b_wr = 1'b0; b_ctrl = 3'b010; b_addr = 32'h20;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL rr_first_tie: ready a/b=%b%b required 10", a_ready, b_ready);
    else n_pass++;
    @(posedge clk); #1; a_valid = 1'b0;
    k = 0; rsp_seen = 1'b0;
    while (k < 8) begin
      @(negedge clk); #1; k++;
      if (k == 2) rsp_seen = rspa_valid && (rspa_data === model_load(32'h10, 3'b010));
      if (b_ready) break;
    end
    n_checks++;
    if (k !== 3 || !rsp_seen) $display("FAIL rr_second_grant: b granted after %0d cycles rspA=%0b required 3/1", k, rsp_seen);
    else n_pass++;
    @(posedge clk); #1; b_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (rspb_valid !== 1'b1 || rspb_data !== model_load(32'h20, 3'b010))
      $display("FAIL rr_b_response: valid=%b data=%h required 1/%h", rspb_valid, rspb_data, model_load(32'h20, 3'b010));
    else n_pass++;
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1;
    ca = 0; cb = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      ca += int'(fp_a_ready); cb += int'(fp_b_ready);
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (cb !== 0 || ca !== 4) $display("FAIL fixed_priority: a grants=%0d b grants=%0d required 4/0", ca, cb);
    else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    check_access("b_load_h_misaligned", 1'b1, 1'b0, 3'b001, 32'h11, 32'd0);
    check_access("b_load_w_over_top", 1'b1, 1'b0, 3'b010, 32'h3FE, 32'd0);
    check_access("b_load_w_last_word", 1'b1, 1'b0, 3'b010, 32'h3FC, 32'd0);
    check_access("a_load_b_last_byte", 1'b0, 1'b0, 3'b100, 32'h3FF, 32'd0);
    check_access("a_load_h_wrap", 1'b0, 1'b0, 3'b101, 32'hFFFFFFFE, 32'd0);
    check_access("a_ctrl_011", 1'b0, 1'b0, 3'b011, 32'h40, 32'd0);
  endtask

  task automatic test_signext();
    check_access("a_store_bu_illegal", 1'b0, 1'b1, 3'b100, 32'h20, 32'h11111111);
    check_access("a_load_after_illegal", 1'b0, 1'b0, 3'b010, 32'h20, 32'd0);
    check_access("store_b_80", 1'b0, 1'b1, 3'b000, 32'h20, 32'h12345680);
    check_access("load_b_signed", 1'b1, 1'b0, 3'b000, 32'h20, 32'd0);
    check_access("load_bu", 1'b1, 1'b0, 3'b100, 32'h20, 32'd0);
    n_checks++;
    if (model_load(32'h20, 3'b000) !== 32'hFFFFFF80 || model_load(32'h20, 3'b100) !== 32'h00000080)
      $display("FAIL signext_model: b=%h bu=%h required ffffff80/00000080",
               model_load(32'h20, 3'b000), model_load(32'h20, 3'b100));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit any_rsp;
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_wr = 1'b1; a_ctrl = 3'b010; a_addr = 32'h40; a_wdata = 32'hCAFEF00D;
    @(posedge clk); #1; a_valid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    n_checks++;
    if (dm_wr !== 1'b0) $display("FAIL reset_mid_dmwr: got %b required 0", dm_wr);
    else n_pass++;
    @(posedge clk); #1; rst = 1'b0;
    any_rsp = 1'b0;
    repeat (3) begin @(negedge clk); any_rsp |= rspa_valid | rspb_valid; end
    n_checks++;
    if (any_rsp !== 1'b0 || {mem[67], mem[66], mem[65], mem[64]} !== model_load(32'h40, 3'b010))
      $display("FAIL reset_mid_abort: rsp=%b mem=%h required 0/%h", any_rsp,
               {mem[67], mem[66], mem[65], mem[64]}, model_load(32'h40, 3'b010));
    else n_pass++;
    a_valid = 1'b1; a_wr = 1'b0; b_valid = 1'b1; b_wr = 1'b0; b_ctrl = 3'b010; b_addr = 32'h0;
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL reset_mid_tie: ready a/b=%b%b required 10", a_ready, b_ready);
    else n_pass++;
    @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_valid();
    bit bad;
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_wr = 1'b0; a_ctrl = 3'b010; a_addr = 32'h0;
    @(posedge clk); #1; a_valid = 1'b0;
    bad = 1'b0;
    @(negedge clk); b_valid = 1'b1; b_wr = 1'b1; b_ctrl = 3'b010; b_addr = 32'h80; b_wdata = 32'h55AA55AA;
    #1; bad |= b_ready;
    @(negedge clk); #1; bad |= b_ready; b_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bad |= a_ready | b_ready | dm_wr | rspa_valid | rspb_valid | (dm_ctrl !== 3'b010) | (dm_address !== 32'd0);
    end
    n_checks++;
    if (bad !== 1'b0 || mem[128] !== ref_mem[128])
      $display("FAIL drop_valid: activity=%b mem[0x80]=%h required 0/%h", bad, mem[128], ref_mem[128]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [2:0] c;
    int r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) addr = 32'($urandom_range(0, 1023));
      else if (r == 7) addr = 32'(1024 - $urandom_range(1, 4));
      else if (r == 8) addr = 32'($urandom_range(1024, 1100));
      else addr = $urandom;
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1 && size_of(c) > 1) addr = addr & ~32'(size_of(c) - 1);
      check_access("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, addr, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_arbitration();
    test_errors();
    test_signext();
    test_reset_mid();
    test_drop_valid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
